dff_serial_tx: RTL and testbench
================================

Name: dff_serial_tx

Overview:
- Transmit end of the team's parallel register path. It accepts a WIDTH-bit word over a valid/ready handshake and serialises it onto one line.
- Line format: idle-high, one start bit (0), WIDTH data bits, one stop bit (1). Each bit is held for BAUD_DIV clocks.
- Sits between a parallel register stage and the matching serial receiver, which rebuilds the word into a register.

Parameters:
- WIDTH, 4, data word width in bits (>=1)
- BAUD_DIV, 4, clock cycles per line bit (>=1; 1 is legal)
- LSB_FIRST, 1, 1 = data bits sent bit0 first; 0 = MSB first

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- din  input  WIDTH  parallel word to send
- din_valid  input  1  din holds a word to send
- din_ready  output  1  block can accept a word this cycle
- tx  output  1  serial line, registered
- busy  output  1  a frame is in progress
- done  output  1  one-cycle pulse in the last clock of the stop bit

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, also mid-frame):
  - state=IDLE, tx=1, busy=0, done=0, din_ready=1.
  - Baud counter, bit counter and shift register are cleared.
  - An in-flight frame is abandoned. The line returns high with no stop bit.
- Handshake:
  - din_ready = (state==IDLE).
  - A transfer happens at a rising edge where din_valid=1 and din_ready=1. din is latched into the shift register at that edge.
  - After acceptance, changes on din are ignored.
  - din_valid while busy is ignored; no word is dropped. The source holds valid until ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on acceptance. tx=0, busy=1, baud counter=0.
  - START -> DATA after BAUD_DIV cycles. tx = first data bit, bit counter=0.
  - DATA: each bit is held BAUD_DIV cycles, then the register shifts.
  - DATA -> STOP after bit WIDTH-1 completes. tx=1.
  - STOP -> IDLE after BAUD_DIV cycles.
- done is high during exactly the final clock of STOP.
- Timing, with acceptance at edge k:
  - Start bit spans edges k..k+B-1.
  - Data bit i spans k+(i+1)B .. k+(i+2)B-1.
  - Stop bit spans k+(W+1)B .. k+(W+2)B-1.
  - IDLE and din_ready=1 after edge k+(W+2)B.
  - Frame length is exactly (WIDTH+2)*BAUD_DIV clocks.
- Back-to-back: with din_valid held high, the next acceptance is at edge k+(W+2)B+1. The line shows exactly one idle-high clock between frames.
- Baud counter counts 0..BAUD_DIV-1 and wraps. With BAUD_DIV=1 it is constant 0 and every cycle is a bit boundary.
- Bit counter width is clog2(WIDTH), minimum 1, and must not overflow at WIDTH=1.
- Bit order follows LSB_FIRST: shift right and emit bit 0, or shift left and emit bit WIDTH-1.
- tx, busy and done are all registered, so they are glitch-free.

Decomposition:
- Shared package `dff_serial_pkg` holds:
  - state enum {IDLE, START, DATA, STOP}
  - localparams IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1
  - a clog2-based counter-width helper
- The package is reused by the matching receiver.
- One sub-module is natural: `baud_tick_gen`, a BAUD_DIV counter with a clear input and a one-cycle tick output at count BAUD_DIV-1.

Test Plan:
1. Reset values (WIDTH=4, BAUD_DIV=4): assert rst=0 -> tx=1, busy=0, done=0, din_ready=1 immediately, with no clock edge needed.
2. Single frame, din=4'hA, LSB_FIRST=1, one-cycle valid:
   - tx = 0,0,1,0,1,1, each held exactly 4 clocks (24 total).
   - done pulses in clock 24 only; din_ready returns at clock 25.
3. MSB first, LSB_FIRST=0, din=4'h3 -> tx = 0,0,0,1,1,1, each held 4 clocks.
4. Back-to-back, din_valid held high with 4'h5 then 4'hC -> two frames separated by exactly one idle-high clock, each frame 24 clocks.
5. Busy and reset mid-frame:
   - Change din and pulse din_valid mid-frame -> the frame is unchanged and no extra frame follows.
   - Assert rst during data bit 2 -> tx=1 and busy=0 asynchronously.
   - After release, a new word 4'hF transmits correctly.
6. Corner parameters, BAUD_DIV=1 and WIDTH=1, din=1 -> tx = 0,1,1 on consecutive clocks. done is in the 3rd clock, and din_ready returns on the 4th clock.

Source files
------------

// File: rtl/dff_serial_pkg.sv
// Shared types and constants for the serial register-path transmitter/receiver pair.
package dff_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_serial_tx_baud_tick_gen.sv
// Baud divider: counts 0..BAUD_DIV-1, ticks on the last count, held at 0 by clear.
module baud_tick_gen
    import dff_serial_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c,
    output logic tick_next_c
);

    localparam int unsigned CW = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise wrap at the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c      = (cnt_q == LAST);
    // Lookahead lets the parent register a flag aligned with the tick cycle.
    assign tick_next_c = (cnt_d == LAST);

endmodule

// File: rtl/dff_serial_tx.sv
// Serialiser: start bit, WIDTH data bits, stop bit, each held BAUD_DIV clocks.
module dff_serial_tx
    import dff_serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned BAUD_DIV  = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = cnt_width(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tick_c;
    logic             tick_next_c;
    logic             baud_clear_c;
    logic [WIDTH-1:0] shifted_c;
    logic             head_c;
    logic             shifted_head_c;

    // Counter sits at zero while idle so a frame starts on a fresh bit period.
    assign baud_clear_c = (state_q == IDLE);

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk         (clk),
        .rst_n       (rst),
        .clear       (baud_clear_c),
        .tick_c      (tick_c),
        .tick_next_c (tick_next_c)
    );

    // Outgoing bit sits at the emitting end of the shift register.
    always_comb begin
        if (LSB_FIRST) begin
            shifted_c      = shift_q >> 1;
            head_c         = shift_q[0];
            shifted_head_c = shifted_c[0];
        end else begin
            shifted_c      = shift_q << 1;
            head_c         = shift_q[WIDTH-1];
            shifted_head_c = shifted_c[WIDTH-1];
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                if (din_valid) begin
                    state_d   = START;
                    shift_d   = din;
                    bit_cnt_d = '0;
                    tx_d      = START_LEVEL;
                end
            end
            START: begin
                if (tick_c) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = head_c;
                end
            end
            DATA: begin
                if (tick_c) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = STOP;
                        tx_d    = STOP_LEVEL;
                    end else begin
                        shift_d   = shifted_c;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = shifted_head_c;
                    end
                end
            end
            STOP: begin
                if (tick_c) begin
                    state_d = IDLE;
                    tx_d    = IDLE_LEVEL;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase

        busy_d = (state_d != IDLE);
        // Final clock of the stop bit is the one whose baud count is the last.
        done_d = (state_d == STOP) && tick_next_c;
    end

    // State and output registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign din_ready = (state_q == IDLE);
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed bench for dff_serial_tx: two 4-bit/4-clock instances (LSB and MSB first)
// and one 1-bit/1-clock corner instance.
module tb_dff_serial_tx;

    logic clk;
    logic rst;

    logic [3:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       tx_a, tx_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    logic [0:0] din_c;
    logic       valid_c, ready_c, tx_c, busy_c, done_c;

    logic       sel;
    logic       tx_s, busy_s, done_s, ready_s;

    int checks = 0;
    int errors = 0;

    dff_serial_tx #(.WIDTH(4), .BAUD_DIV(4), .LSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    dff_serial_tx #(.WIDTH(4), .BAUD_DIV(4), .LSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    dff_serial_tx #(.WIDTH(1), .BAUD_DIV(1), .LSB_FIRST(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .din(din_c), .din_valid(valid_c), .din_ready(ready_c),
        .tx(tx_c), .busy(busy_c), .done(done_c)
    );

    assign tx_s    = sel ? tx_b    : tx_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign done_s  = sel ? done_b  : done_a;
    assign ready_s = sel ? ready_b : ready_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for 4-bit frame bit j (0 = start, 1..4 = data, 5 = stop).
    function automatic logic exp_bit(input logic [3:0] w, input bit lsb, input int j);
        if (j == 0) return 1'b0;
        if (j == 5) return 1'b1;
        return lsb ? w[j-1] : w[4-j];
    endfunction

    // Called #1 after the accepting edge; checks 24 frame clocks then the idle clock.
    // poke >= 0 drives a new din and a one-clock valid at that frame clock.
    task automatic check_frame(input logic [3:0] word, input bit lsb, input int poke, input string tag);
        for (int i = 0; i < 24; i++) begin
            if (i > 0) step();
            check({tag, "_tx"},    {31'd0, tx_s},    {31'd0, exp_bit(word, lsb, i / 4)});
            check({tag, "_done"},  {31'd0, done_s},  {31'd0, (i == 23)});
            check({tag, "_busy"},  {31'd0, busy_s},  32'd1);
            check({tag, "_ready"}, {31'd0, ready_s}, 32'd0);
            if (poke >= 0) begin
                valid_a = (i == poke);
                if (i == poke) din_a = ~word;
            end
        end
        step();
        check({tag, "_idle_tx"},    {31'd0, tx_s},    32'd1);
        check({tag, "_idle_busy"},  {31'd0, busy_s},  32'd0);
        check({tag, "_idle_done"},  {31'd0, done_s},  32'd0);
        check({tag, "_idle_ready"}, {31'd0, ready_s}, 32'd1);
    endtask

    initial begin
        rst     = 1'b1;
        din_a   = '0; din_b = '0; din_c = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        sel     = 1'b0;

        // Asynchronous reset, observed before the first rising edge.
        #3 rst = 1'b0;
        #1;
        check("rst_tx",    {31'd0, tx_a},    32'd1);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_done",  {31'd0, done_a},  32'd0);
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        step();
        step();
        @(negedge clk) rst = 1'b1;
        step();

        // LSB-first 4'hA.
        sel = 1'b0; din_a = 4'hA; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check_frame(4'hA, 1'b1, -1, "lsb_a");

        // MSB-first 4'h3.
        sel = 1'b1; din_b = 4'h3; valid_b = 1'b1;
        step();
        valid_b = 1'b0;
        check_frame(4'h3, 1'b0, -1, "msb_3");
        sel = 1'b0;

        // Back-to-back with valid held: exactly one idle clock between frames.
        din_a = 4'h5; valid_a = 1'b1;
        step();
        din_a = 4'hC;
        check_frame(4'h5, 1'b1, -1, "b2b_5");
        step();
        valid_a = 1'b0;
        check_frame(4'hC, 1'b1, -1, "b2b_c");

        // valid and din changes while busy are ignored; nothing follows.
        din_a = 4'h9; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check_frame(4'h9, 1'b1, 6, "busy_9");
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("after_busy_tx",   {31'd0, tx_a},   32'd1);
            check("after_busy_busy", {31'd0, busy_a}, 32'd0);
        end

        // Reset during data bit 2 (a 0 bit of 4'hB) drops the line high immediately.
        din_a = 4'hB; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 13; i++) step();
        check("pre_rst_tx", {31'd0, tx_a}, 32'd0);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_tx",    {31'd0, tx_a},    32'd1);
        check("mid_rst_busy",  {31'd0, busy_a},  32'd0);
        check("mid_rst_done",  {31'd0, done_a},  32'd0);
        check("mid_rst_ready", {31'd0, ready_a}, 32'd1);
        @(negedge clk) rst = 1'b1;
        step();
        check("post_rst_idle_tx", {31'd0, tx_a}, 32'd1);
        din_a = 4'hF; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        check_frame(4'hF, 1'b1, -1, "post_rst_f");

        // WIDTH=1, BAUD_DIV=1: tx 0,1,1 then idle on the 4th clock.
        din_c = 1'b1; valid_c = 1'b1;
        step();
        valid_c = 1'b0;
        check("c1_tx",    {31'd0, tx_c},    32'd0);
        check("c1_done",  {31'd0, done_c},  32'd0);
        check("c1_ready", {31'd0, ready_c}, 32'd0);
        step();
        check("c2_tx",    {31'd0, tx_c},    32'd1);
        check("c2_done",  {31'd0, done_c},  32'd0);
        step();
        check("c3_tx",    {31'd0, tx_c},    32'd1);
        check("c3_done",  {31'd0, done_c},  32'd1);
        check("c3_busy",  {31'd0, busy_c},  32'd1);
        step();
        check("c4_ready", {31'd0, ready_c}, 32'd1);
        check("c4_busy",  {31'd0, busy_c},  32'd0);
        check("c4_done",  {31'd0, done_c},  32'd0);
        check("c4_tx",    {31'd0, tx_c},    32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
